// File: rtl/pluto_spi_master.sv
// SPI master, mode 0, fixed-length frames of NBYTES bytes.
// Sequence per frame: SETUP (SSEL low, SCK low) -> XFER (16*NBYTES SCK edges)
// -> HOLD (SSEL still low) -> GAP (SSEL high) -> IDLE with a one-cycle done pulse.
// Byte 0 goes first, each byte MSB first; rx_frame uses the same byte layout.
module pluto_spi_master #(
  parameter int NBYTES = 20,
  parameter int DIV    = 4
) (
  input  logic                clk,
  input  logic                nRESET,
  input  logic                start,
  input  logic [8*NBYTES-1:0] tx_frame,
  output logic [8*NBYTES-1:0] rx_frame,
  output logic                busy,
  output logic                done,
  output logic                SCK,
  output logic                MOSI,
  input  logic                MISO,
  output logic                SSEL
);

  localparam int NBITS = 8 * NBYTES;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int IW    = $clog2(NBITS);
  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(NBITS);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [NBITS-1:0]  tx_buf_q, tx_buf_d;
  logic [NBITS-1:0]  rx_buf_q, rx_buf_d;
  logic [NBITS-1:0]  rx_frame_q, rx_frame_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              ssel_q, ssel_d;
  logic              done_q, done_d;

  logic              div_end;
  logic              edge_en;
  logic              rise;
  logic              fall;
  logic [BW-1:0]     bit_nxt;

  // Frame bit n lives at buffer position n ^ 7: byte n/8, bit 7 - n%8.
  assign div_end = (div_q == DIV_LAST);
  assign edge_en = (state_q == XFER) && div_end && (bit_q != BIT_END);
  assign rise    = edge_en && !sck_q;
  assign fall    = edge_en && sck_q;
  assign bit_nxt = bit_q + BW'(1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!nRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: each timed phase ends when the divider reaches DIV-1;
  // XFER ends one cycle after the last falling SCK edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)            state_d = SETUP;
      SETUP:   if (div_end)          state_d = XFER;
      XFER:    if (bit_q == BIT_END) state_d = HOLD;
      HOLD:    if (div_end)          state_d = GAP;
      GAP:     if (div_end)          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output and datapath next-state: divider, bit counter, shift buffers and
  // the registered SPI pins.
  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    div_d      = div_q;
    bit_d      = bit_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
    rx_frame_d = rx_frame_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ssel_d     = ssel_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (start) begin
          tx_buf_d = tx_frame;
          ssel_d   = 1'b0;
          mosi_d   = tx_frame[7];
        end
      end
      SETUP: div_d = div_end ? 8'd0 : div_q + 8'd1;
      XFER: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (bit_q == BIT_END) div_d = '0;
        if (rise) begin
          sck_d = 1'b1;
          rx_buf_d[IW'(bit_q ^ BW'(7))] = MISO;
        end
        if (fall) begin
          sck_d = 1'b0;
          bit_d = bit_nxt;
          // After the last bit MOSI keeps its value until GAP.
          if (bit_nxt != BIT_END) mosi_d = tx_buf_q[IW'(bit_nxt ^ BW'(7))];
        end
      end
      HOLD: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) begin
          ssel_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      GAP: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) begin
          done_d     = 1'b1;
          rx_frame_d = rx_buf_q;
        end
      end
      default: div_d = '0;
    endcase
  end

  // Datapath registers; the SPI pins come straight from flops.
  always_ff @(posedge clk) begin
    // NOTE: the wide buffers are reset as well, because rx_frame must read
    // zero after a reset, even one that aborts a frame.
    if (!nRESET) begin
      div_q      <= '0;
      bit_q      <= '0;
      tx_buf_q   <= '0;
      rx_buf_q   <= '0;
      rx_frame_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ssel_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      rx_frame_q <= rx_frame_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ssel_q     <= ssel_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rx_frame = rx_frame_q;
  assign SCK      = sck_q;
  assign MOSI     = mosi_q;
  assign SSEL     = ssel_q;

endmodule
